// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_t;

    function automatic int unsigned cntWidth(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_WIDTH = cntWidth(DIV_WIDTH);

endpackage

// File: rtl/div_if.sv
// Start/Done handshake and operand/result bus between the datapath control and div_unit.
// With DIV_UNSIGNED_EN defined, an Unsigned request qualifier is carried alongside Start.
interface div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Done;
    logic             DivZero;
    logic             Busy;
`ifdef DIV_UNSIGNED_EN
    logic             Unsigned;

    modport master (
        output Start, A, B, Unsigned,
        input  Hi, Lo, Done, DivZero, Busy
    );

    modport slave (
        input  Start, A, B, Unsigned,
        output Hi, Lo, Done, DivZero, Busy
    );
`else
    modport master (
        output Start, A, B,
        input  Hi, Lo, Done, DivZero, Busy
    );

    modport slave (
        input  Start, A, B,
        output Hi, Lo, Done, DivZero, Busy
    );
`endif
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             dvdMsb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             qBit
);

    // One extra bit so a full-width unsigned divisor cannot overflow the trial value.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial  = {remIn, dvdMsb};
    assign diff   = trial - {1'b0, divisor};
    assign qBit   = (trial >= {1'b0, divisor});
    assign remOut = qBit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider (one quotient bit per cycle) producing Lo = quotient, Hi = remainder.
// Optional feature macro: DIV_UNSIGNED_EN adds an Unsigned request qualifier (divu).
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    div_if.slave bus
);

    localparam int unsigned CntW = (WIDTH == DIV_WIDTH) ? CNT_WIDTH : cntWidth(WIDTH);

    div_state_t       stateQ, stateD;
    logic [CntW-1:0]  cntQ, cntD;
    logic [WIDTH-1:0] remQ, remD;
    logic [WIDTH-1:0] dvdQ, dvdD;
    logic [WIDTH-1:0] quoQ, quoD;
    logic [WIDTH-1:0] dsrQ, dsrD;
    logic [WIDTH-1:0] hiQ, hiD;
    logic [WIDTH-1:0] loQ, loD;
    logic             sAQ, sAD;
    logic             sQQ, sQD;
    logic             doneQ, doneD;
    logic             zeroQ, zeroD;

    logic             isSigned;
    logic             negA, negB;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH-1:0] stepRem;
    logic             stepBit;

`ifdef DIV_UNSIGNED_EN
    assign isSigned = ~bus.Unsigned;
`else
    assign isSigned = 1'b1;
`endif

    // The most negative value negates to itself, which read as unsigned is its magnitude.
    assign negA = isSigned & bus.A[WIDTH-1];
    assign negB = isSigned & bus.B[WIDTH-1];
    assign absA = negA ? -bus.A : bus.A;
    assign absB = negB ? -bus.B : bus.B;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .remIn   (remQ),
        .dvdMsb  (dvdQ[WIDTH-1]),
        .divisor (dsrQ),
        .remOut  (stepRem),
        .qBit    (stepBit)
    );

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        remD   = remQ;
        dvdD   = dvdQ;
        quoD   = quoQ;
        dsrD   = dsrQ;
        sAD    = sAQ;
        sQD    = sQQ;
        hiD    = hiQ;
        loD    = loQ;
        doneD  = 1'b0;
        zeroD  = 1'b0;

        case (stateQ)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.B == '0) begin
                        doneD = 1'b1;
                        zeroD = 1'b1;
                    end else begin
                        dvdD   = absA;
                        dsrD   = absB;
                        sAD    = negA;
                        sQD    = negA ^ negB;
                        remD   = '0;
                        quoD   = '0;
                        cntD   = CntW'(WIDTH);
                        stateD = RUN;
                    end
                end
            end
            RUN: begin
                remD = stepRem;
                dvdD = {dvdQ[WIDTH-2:0], 1'b0};
                quoD = {quoQ[WIDTH-2:0], stepBit};
                cntD = cntQ - CntW'(1);
                if (cntQ == CntW'(1)) begin
                    stateD = FIX;
                end
            end
            FIX: begin
                loD    = sQQ ? -quoQ : quoQ;
                hiD    = sAQ ? -remQ : remQ;
                doneD  = 1'b1;
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            remQ   <= '0;
            dvdQ   <= '0;
            quoQ   <= '0;
            dsrQ   <= '0;
            sAQ    <= 1'b0;
            sQQ    <= 1'b0;
            hiQ    <= '0;
            loQ    <= '0;
            doneQ  <= 1'b0;
            zeroQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            remQ   <= remD;
            dvdQ   <= dvdD;
            quoQ   <= quoD;
            dsrQ   <= dsrD;
            sAQ    <= sAD;
            sQQ    <= sQD;
            hiQ    <= hiD;
            loQ    <= loD;
            doneQ  <= doneD;
            zeroQ  <= zeroD;
        end
    end

    assign bus.Hi      = hiQ;
    assign bus.Lo      = loQ;
    assign bus.Done    = doneQ;
    assign bus.DivZero = zeroQ;
    assign bus.Busy    = (stateQ != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(
        .WIDTH (W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } vec_t;

    int total = 0;
    int bad = 0;
    bit unsMode = 1'b0;
    logic [W-1:0] modelHi = '0;
    logic [W-1:0] modelLo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder follows the dividend's sign.
    function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, q64, r64;
        sa = uns ? longint'({32'h0, a}) : longint'($signed(a));
        sb = uns ? longint'({32'h0, b}) : longint'($signed(b));
        q64 = sa / sb;
        r64 = sa % sb;
        q = q64[W-1:0];
        r = r64[W-1:0];
    endfunction

    // Called at a negedge; returns at the following negedge (first cycle after the Start edge).
    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
`ifdef DIV_UNSIGNED_EN
        bus.Unsigned = unsMode;
`endif
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
`ifdef DIV_UNSIGNED_EN
        bus.Unsigned = ~unsMode;
`endif
    endtask

    task automatic waitDone(input int startN, output int lat, output int busyCnt);
        lat = startN;
        busyCnt = 0;
        while (!bus.Done && lat < 60) begin
            if (bus.Busy) busyCnt++;
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic runVec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lo, input logic [W-1:0] hi);
        int lat, busyCnt;
        startOp(a, b);
        waitDone(1, lat, busyCnt);
        check({name, ".lat"}, lat, 34);
        check({name, ".busy"}, busyCnt, 33);
        check({name, ".lo"}, bus.Lo, lo);
        check({name, ".hi"}, bus.Hi, hi);
        check({name, ".dz"}, bus.DivZero, 1'b0);
        check({name, ".busyAtDone"}, bus.Busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[10];
        int lat, busyCnt, doneSeen;
        logic [W-1:0] a, b, q, r;
        logic [W-1:0] specials[4];

        vecs[0] = '{32'd7,         32'd2,         32'd3,         32'd1};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[2] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF};
        vecs[3] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vecs[4] = '{32'h80000000,  32'd1,         32'h80000000,  32'd0};
        vecs[5] = '{32'd100,       32'd7,         32'd14,        32'd2};
        vecs[6] = '{32'd9,         32'd3,         32'd3,         32'd0};
        vecs[7] = '{32'd0,         32'd5,         32'd0,         32'd0};
        vecs[8] = '{32'd5,         32'h80000000,  32'd0,         32'd5};
        vecs[9] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000001,  32'd0};
        specials[0] = 32'h80000000;
        specials[1] = 32'hFFFFFFFF;
        specials[2] = 32'h00000001;
        specials[3] = 32'h7FFFFFFF;

        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef DIV_UNSIGNED_EN
        bus.Unsigned = 1'b0;
`endif
        #1;
        check("rst.hi", bus.Hi, '0);
        check("rst.lo", bus.Lo, '0);
        check("rst.done", bus.Done, 1'b0);
        check("rst.dz", bus.DivZero, 1'b0);
        check("rst.busy", bus.Busy, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 10; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
            @(negedge Clk);
        end

        // Divide by zero leaves the previous 7/2 result in place.
        runVec("load72", 32'd7, 32'd2, 32'd3, 32'd1);
        @(negedge Clk);
        startOp(32'd5, 32'd0);
        waitDone(1, lat, busyCnt);
        check("dz.lat", lat, 1);
        check("dz.flag", bus.DivZero, 1'b1);
        check("dz.busy", busyCnt, 0);
        check("dz.hi", bus.Hi, 32'd1);
        check("dz.lo", bus.Lo, 32'd3);
        @(negedge Clk);
        check("dz.doneAfter", bus.Done, 1'b0);
        check("dz.flagAfter", bus.DivZero, 1'b0);

        // Start while busy is dropped.
        startOp(32'd100, 32'd7);
        repeat (8) @(negedge Clk);
        bus.Start = 1'b1;
        bus.A = 32'd9;
        bus.B = 32'd3;
        @(negedge Clk);
        bus.Start = 1'b0;
        waitDone(10, lat, busyCnt);
        check("ign.lat", lat, 34);
        check("ign.lo", bus.Lo, 32'd14);
        check("ign.hi", bus.Hi, 32'd2);
        // Start issued in the Done cycle is accepted.
        startOp(32'd9, 32'd3);
        waitDone(1, lat, busyCnt);
        check("b2b.lat", lat, 34);
        check("b2b.lo", bus.Lo, 32'd3);
        check("b2b.hi", bus.Hi, 32'd0);
        @(negedge Clk);

        // Reset mid-operation aborts with no completion pulse.
        startOp(32'd100, 32'd7);
        repeat (14) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("abort.busy", bus.Busy, 1'b0);
        check("abort.hi", bus.Hi, '0);
        check("abort.lo", bus.Lo, '0);
        check("abort.done", bus.Done, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Done) doneSeen++;
        end
        check("abort.noDone", doneSeen, 0);
        modelHi = '0;
        modelLo = '0;

`ifdef DIV_UNSIGNED_EN
        unsMode = 1'b1;
        runVec("divu", 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1);
        unsMode = 1'b0;
        @(negedge Clk);
        modelHi = 32'd1;
        modelLo = 32'h7FFFFFFF;
`endif

        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(0, 16) - 8;
                2:       b = '0;
                3:       b = specials[$urandom_range(0, 3)];
                default: begin
                    a = specials[$urandom_range(0, 3)];
                    b = $urandom_range(1, 3);
                end
            endcase
`ifdef DIV_UNSIGNED_EN
            unsMode = $urandom_range(0, 1);
`endif
            startOp(a, b);
            waitDone(1, lat, busyCnt);
            if (b == '0) begin
                check("rnd.zlat", lat, 1);
                check("rnd.zflag", bus.DivZero, 1'b1);
            end else begin
                refDiv(a, b, unsMode, q, r);
                modelLo = q;
                modelHi = r;
                check("rnd.lat", lat, 34);
                check("rnd.flag", bus.DivZero, 1'b0);
            end
            check("rnd.lo", bus.Lo, modelLo);
            check("rnd.hi", bus.Hi, modelHi);
            if ($urandom_range(0, 1) == 1) @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
